pixel_sram_writer: RTL and testbench
====================================

PIXEL_SRAM_WRITER -- requirements
Module: pixel_sram_writer

Interface
REQ-001 Parameter FB_WIDTH, default 640, frame width in pixels.
REQ-002 Parameter FB_HEIGHT, default 480, frame height in pixels.
REQ-003 Parameter FIFO_DEPTH, default 4, pixel buffer entries (power of 2, >=2).
REQ-004 Port clk  in  1  sole clock, all state on rising edge.
REQ-005 Port n_rst  in  1  synchronous active-low reset.
REQ-006 Port pix_valid  in  1  pixel write request.
REQ-007 Port pix_x  in  10  pixel column.
REQ-008 Port pix_y  in  9  pixel row.
REQ-009 Port pix_color  in  24  RGB888 pixel value.
REQ-010 Port pix_ready  out  1  buffer can accept a pixel.
REQ-011 Port sram_read_enable  out  1  SRAM read strobe.
REQ-012 Port sram_write_enable  out  1  SRAM write strobe.
REQ-013 Port sram_address  out  22  SRAM word address, always even.
REQ-014 Port sram_write_data  out  48  two-word access; [23:0] even word, [47:24] odd word.
REQ-015 Port sram_read_data  in  48  SRAM read data, valid same cycle as sram_read_enable.
REQ-016 Port busy  out  1  high while FIFO non-empty or FSM not IDLE.
REQ-017 Port err_oob  out  1  one-cycle pulse on dropped out-of-range pixel.

Function
REQ-018 Pixel accepted on edge where pix_valid && pix_ready; pix_ready = FIFO not full (registered count, no full-bypass).
REQ-019 Accepted pixel with pix_x >= FB_WIDTH or pix_y >= FB_HEIGHT is not buffered; err_oob pulses next cycle.
REQ-020 Word address = pix_y*FB_WIDTH + pix_x (22-bit unsigned); sram_address = word address with bit0 cleared; bit0 selects lane.
REQ-021 FSM states IDLE, RD, WR; IDLE->RD when FIFO non-empty (pop head into op register).
REQ-022 RD (one cycle): sram_read_enable=1, sram_address=op address; sram_read_data captured at end of cycle; ->WR.
REQ-023 WR (one cycle): sram_write_enable=1, write data = captured data with op lane replaced by op color; ->IDLE.
REQ-024 Single-pixel latency: RD cycle follows first IDLE cycle with FIFO non-empty; WR immediately after.
REQ-025 sram_read_enable and sram_write_enable never high in same cycle.
REQ-026 sram_address/sram_write_data drive 0 when neither strobe high.
REQ-027 Push and pop in same cycle allowed when not full; count unchanged.
REQ-028 FIFO pointers wrap modulo FIFO_DEPTH; ordering strictly FIFO.

Reset
REQ-029 n_rst low at an edge: FSM->IDLE, FIFO emptied, op and capture registers cleared.
REQ-030 Reset values: pix_ready=0 during reset, 1 after; all strobes, address, data, busy, err_oob = 0.
REQ-031 Reset mid RD/WR aborts operation; no strobe asserted in the cycle following reset edge.

Configuration
REQ-032 Macro PIX_PAIR_MERGE_EN.
REQ-033 Defined: in IDLE, if FIFO holds >=2 entries, head lane 0, next entry same row and x = head x+1, pop both and go directly to WR writing both colors (no RD).
REQ-034 Undefined: every pixel uses RD then WR; no pair detection logic.

Verification
REQ-035 Reset, push (x=9,y=0,color=0x000009), SRAM word 8 = 0xAAAAAA -> RD addr 8, then WR addr 8 data 0x000009_AAAAAA.
REQ-036 Push (x=640,y=0) -> err_oob pulse, no strobes, busy stays 0.
REQ-037 Fill 4 pixels back-to-back with no drain -> pix_ready low after 4th accept, recovers after first pop.
REQ-038 Merge on: push (8,1,0x111111),(9,1,0x222222) -> single WR addr 648 data 0x222222_111111, no RD; merge off -> two RD/WR pairs.
REQ-039 Assert n_rst during RD -> no WR follows, busy=0, FIFO empty.
REQ-040 Random 1000-pixel stream vs reference frame model -> final SRAM image matches, strobes never overlap.

Source files
------------

// File: rtl/pixel_sram_writer_if.sv
// pixel_sram_writer_if: pixel request handshake plus two-word SRAM bus of pixel_sram_writer.
interface pixel_sram_writer_if;
   logic        pix_valid;
   logic [9:0]  pix_x;
   logic [8:0]  pix_y;
   logic [23:0] pix_color;
   logic        pix_ready;
   logic        sram_read_enable;
   logic        sram_write_enable;
   logic [21:0] sram_address;
   logic [47:0] sram_write_data;
   logic [47:0] sram_read_data;
   logic        busy;
   logic        err_oob;
   modport master (
      input  pix_valid, pix_x, pix_y, pix_color, sram_read_data,
      output pix_ready, sram_read_enable, sram_write_enable, sram_address, sram_write_data, busy, err_oob
   );
   modport slave (
      output pix_valid, pix_x, pix_y, pix_color, sram_read_data,
      input  pix_ready, sram_read_enable, sram_write_enable, sram_address, sram_write_data, busy, err_oob
   );
endinterface

// File: rtl/pixel_sram_writer.sv
// pixel_sram_writer: buffers pixel writes and read-modify-writes them into a 48-bit two-pixel SRAM word.
// Optional PIX_PAIR_MERGE_EN writes an adjacent even/odd pixel pair in one WR without a read.
module pixel_sram_writer #(
   parameter int FB_WIDTH = 640,
   parameter int FB_HEIGHT = 480,
   parameter int FIFO_DEPTH = 4
) (
   input logic clk,
   input logic n_rst,
   pixel_sram_writer_if.master bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
   typedef enum logic [1:0] {IDLE, RD, WR} state_t;
   state_t state, state_nx;
   logic [9:0] q_x [FIFO_DEPTH];
   logic [8:0] q_y [FIFO_DEPTH];
   logic [23:0] q_color [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0] count;
   logic [21:0] head_addr, op_addr;
   logic [23:0] op_color;
   logic [47:0] cap;
   logic accept, in_range, push, merge;
   logic [1:0] pop_n;

   assign bus.pix_ready = n_rst && count != FULL;
   assign accept = bus.pix_valid && bus.pix_ready;
   assign in_range = 32'(bus.pix_x) < FB_WIDTH && 32'(bus.pix_y) < FB_HEIGHT;
   assign push = accept && in_range;
   assign head_addr = 22'(q_y[rd_ptr]) * 22'(FB_WIDTH) + 22'(q_x[rd_ptr]);

`ifdef PIX_PAIR_MERGE_EN
   logic [AW-1:0] nx_ptr;
   assign nx_ptr = rd_ptr + 1'b1;
   assign merge = count >= (AW+1)'(2) && !head_addr[0] && q_y[nx_ptr] == q_y[rd_ptr] &&
                  q_x[nx_ptr] == q_x[rd_ptr] + 10'd1;
`else
   assign merge = 1'b0;
`endif

   always_ff @(posedge clk) begin
      state <= n_rst ? state_nx : IDLE;
   end

   always_comb begin
      state_nx = state == RD ? WR : state == WR ? IDLE : count != '0 ? (merge ? WR : RD) : IDLE;
      pop_n = state == IDLE && count != '0 ? (merge ? 2'd2 : 2'd1) : 2'd0;
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         op_addr <= '0;
         op_color <= '0;
         cap <= '0;
         bus.err_oob <= 1'b0;
      end else begin
         bus.err_oob <= accept && !in_range;
         count <= count + (AW+1)'(push) - (AW+1)'(pop_n);
         rd_ptr <= rd_ptr + AW'(pop_n);
         if (push) begin
            q_x[wr_ptr] <= bus.pix_x;
            q_y[wr_ptr] <= bus.pix_y;
            q_color[wr_ptr] <= bus.pix_color;
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_n != 2'd0) begin
            op_addr <= head_addr;
            op_color <= q_color[rd_ptr];
         end
         if (state == RD) cap <= bus.sram_read_data;
`ifdef PIX_PAIR_MERGE_EN
         // merged pair: the captured word is synthesized from both colors, so WR writes both lanes
         if (merge && pop_n != 2'd0) cap <= {q_color[nx_ptr], q_color[rd_ptr]};
`endif
      end
   end

   assign bus.sram_read_enable = state == RD;
   assign bus.sram_write_enable = state == WR;
   assign bus.sram_address = state != IDLE ? {op_addr[21:1], 1'b0} : '0;
   assign bus.sram_write_data = state != WR ? '0 : op_addr[0] ? {op_color, cap[23:0]} : {cap[47:24], op_color};
   assign bus.busy = count != '0 || state != IDLE;
endmodule

// File: tb/tb_pixel_sram_writer.sv
// tb_pixel_sram_writer: directed and random pixel streams against an SRAM model and reference frame.
// Expected SRAM transactions are queued when pixels are driven and popped when strobes appear.
module tb_pixel_sram_writer;
   localparam int W = 640;
   localparam int H = 480;
   typedef struct packed {logic we; logic [21:0] addr; logic [47:0] data;} txn_t;
   logic clk = 1'b0;
   logic n_rst = 1'b0;
   logic [23:0] sram [W*H];
   logic [23:0] ref_m [W*H];
   logic sram_init = 1'b0;
   txn_t exp_q [$];
   int n_cmp = 0;
   int n_fail = 0;
   int oob_seen = 0;
   int oob_exp = 0;
   bit mon_on = 0;
   bit sb_on = 0;
   bit auto_sb = 0;

   always #5 clk = ~clk;

   pixel_sram_writer_if bus ();
   pixel_sram_writer #(.FB_WIDTH(W), .FB_HEIGHT(H), .FIFO_DEPTH(4)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));

   function automatic logic [23:0] pat(input int i);
      return i == 8 ? 24'hAAAAAA : 24'(i * 40503 + 7);
   endfunction

   always_comb bus.sram_read_data = bus.sram_read_enable ?
      {sram[int'(bus.sram_address) + 1], sram[int'(bus.sram_address)]} : 48'd0;

   always @(posedge clk) begin
      if (!sram_init) begin
         for (int i = 0; i < W*H; i++) sram[i] <= pat(i);
         sram_init <= 1'b1;
      end else if (bus.sram_write_enable) begin
         sram[int'(bus.sram_address)] <= bus.sram_write_data[23:0];
         sram[int'(bus.sram_address) + 1] <= bus.sram_write_data[47:24];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         txn_t e;
         if (bus.err_oob === 1'b1) oob_seen++;
         chk("strobe_overlap", 64'(bus.sram_read_enable & bus.sram_write_enable), 64'd0);
         if (bus.sram_read_enable || bus.sram_write_enable) begin
            if (sb_on) begin
               chk("sb_underflow", 64'(exp_q.size() == 0), 64'd0);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("txn_we", 64'(bus.sram_write_enable), 64'(e.we));
                  chk("txn_addr", 64'(bus.sram_address), 64'(e.addr));
                  if (e.we) chk("txn_data", 64'(bus.sram_write_data), 64'(e.data));
               end
            end
         end else begin
            chk("idle_addr", 64'(bus.sram_address), 64'd0);
            chk("idle_data", 64'(bus.sram_write_data), 64'd0);
         end
      end
   end

   task automatic push(input int x, input int y, input logic [23:0] c, input bit model);
      int t = 0;
      @(negedge clk);
      bus.pix_valid = 1'b1;
      bus.pix_x = 10'(x);
      bus.pix_y = 9'(y);
      bus.pix_color = c;
      while (bus.pix_ready !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("push_timeout", 64'(t >= 200), 64'd0);
      if (x >= W || y >= H) oob_exp++;
      else if (model) begin
         int a = y * W + x;
         int e = a & ~1;
         ref_m[a] = c;
         if (auto_sb) begin
            exp_q.push_back({1'b0, 22'(e), 48'd0});
            exp_q.push_back({1'b1, 22'(e), ref_m[e+1], ref_m[e]});
         end
      end
      @(posedge clk);
      #1 bus.pix_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      do begin
         @(negedge clk);
         t++;
      end while ((bus.busy !== 1'b0 || exp_q.size() != 0) && t < 500);
      chk("idle_timeout", 64'(t >= 500), 64'd0);
   endtask

   initial begin
      int t;
      int bad;
      bus.pix_valid = 1'b0;
      bus.pix_x = '0;
      bus.pix_y = '0;
      bus.pix_color = '0;
      for (int i = 0; i < W*H; i++) ref_m[i] = pat(i);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 64'(bus.pix_ready), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_re", 64'(bus.sram_read_enable), 64'd0);
      chk("rst_we", 64'(bus.sram_write_enable), 64'd0);
      chk("rst_addr", 64'(bus.sram_address), 64'd0);
      chk("rst_data", 64'(bus.sram_write_data), 64'd0);
      chk("rst_oob", 64'(bus.err_oob), 64'd0);
      n_rst = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", 64'(bus.pix_ready), 64'd1);
      mon_on = 1;
      sb_on = 1;
      auto_sb = 1;

      push(9, 0, 24'h000009, 1);
      @(negedge clk);
      chk("lat_idle_re", 64'(bus.sram_read_enable), 64'd0);
      chk("lat_busy", 64'(bus.busy), 64'd1);
      @(negedge clk);
      chk("rd_strobe", 64'(bus.sram_read_enable), 64'd1);
      chk("rd_addr", 64'(bus.sram_address), 64'd8);
      @(negedge clk);
      chk("wr_strobe", 64'(bus.sram_write_enable), 64'd1);
      chk("wr_addr", 64'(bus.sram_address), 64'd8);
      chk("wr_data", 64'(bus.sram_write_data), 64'h000009AAAAAA);
      @(negedge clk);
      chk("post_wr_busy", 64'(bus.busy), 64'd0);

      push(640, 0, 24'h123456, 1);
      @(negedge clk);
      chk("oob_x_pulse", 64'(bus.err_oob), 64'd1);
      chk("oob_busy", 64'(bus.busy), 64'd0);
      @(negedge clk);
      chk("oob_pulse_end", 64'(bus.err_oob), 64'd0);
      push(5, 480, 24'h654321, 1);
      @(negedge clk);
      chk("oob_y_pulse", 64'(bus.err_oob), 64'd1);
      wait_idle();

      // drain runs at one pixel per three cycles, so six back-to-back pushes reach four entries
      for (int i = 0; i < 6; i++) push(20 + 2*i, 3, 24'(32'h300 + i), 1);
      @(negedge clk);
      chk("full_ready_a", 64'(bus.pix_ready), 64'd0);
      @(negedge clk);
      chk("full_ready_b", 64'(bus.pix_ready), 64'd0);
      @(negedge clk);
      chk("ready_recover", 64'(bus.pix_ready), 64'd1);
      wait_idle();

      push(100, 2, 24'h0000AA, 1);
`ifdef PIX_PAIR_MERGE_EN
      auto_sb = 0;
      push(8, 1, 24'h111111, 1);
      push(9, 1, 24'h222222, 1);
      exp_q.push_back({1'b1, 22'd648, 48'h222222111111});
      auto_sb = 1;
`else
      push(8, 1, 24'h111111, 1);
      push(9, 1, 24'h222222, 1);
`endif
      wait_idle();
      chk("pair_word", 64'({sram[649], sram[648]}), 64'h222222111111);

      push(30, 4, 24'hDEAD01, 0);
      exp_q.push_back({1'b0, 22'd2590, 48'd0});
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (bus.sram_read_enable !== 1'b1 && t < 10);
      chk("rd_seen_before_rst", 64'(t >= 10), 64'd0);
      n_rst = 1'b0;
      @(negedge clk);
      chk("abort_we", 64'(bus.sram_write_enable), 64'd0);
      chk("abort_re", 64'(bus.sram_read_enable), 64'd0);
      chk("abort_busy", 64'(bus.busy), 64'd0);
      n_rst = 1'b1;
      @(negedge clk);
      chk("abort_we_after", 64'(bus.sram_write_enable), 64'd0);
      chk("abort_busy_after", 64'(bus.busy), 64'd0);
      chk("abort_ready", 64'(bus.pix_ready), 64'd1);
      chk("abort_q_empty", 64'(exp_q.size()), 64'd0);
      chk("abort_word", 64'(sram[2590]), 64'(pat(2590)));

`ifdef PIX_PAIR_MERGE_EN
      sb_on = 0;
      auto_sb = 0;
`endif
      for (int i = 0; i < 1000; i++) begin
         int x;
         int y;
         if ($urandom_range(0, 1) == 1) begin
            x = $urandom_range(0, 15);
            y = $urandom_range(0, 3);
         end else begin
            x = $urandom_range(0, W + 20);
            y = $urandom_range(0, H + 5);
         end
         push(x, y, 24'($urandom), 1);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
      end
      wait_idle();
      @(negedge clk);
      bad = 0;
      for (int i = 0; i < W*H; i++) if (sram[i] !== ref_m[i]) bad++;
      chk("image_bad_words", 64'(bad), 64'd0);
      chk("oob_pulses", 64'(oob_seen), 64'(oob_exp));
      chk("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
